// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Sequence tags are compared modulo 2^TAG_W to survive wraparound.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int TAG_W  = 4;

  localparam logic [ADDR_W-1:0] R7   = 3'd7;
  localparam logic [TAG_W-1:0]  HALF = TAG_W'(1) << (TAG_W - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wb_entry_t;

  function automatic logic tag_older(
    input logic [TAG_W-1:0] a,
    input logic [TAG_W-1:0] b
  );
    logic [TAG_W-1:0] d;
    d = b - a;
    return (d != '0) && (d < HALF);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Producer-side handshakes and register-file write ports of the
// writeback arbiter, grouped for connection to the top module.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              req_valid_0;
  logic              req_valid_1;
  logic              req_valid_2;
  logic              req_ready_0;
  logic              req_ready_1;
  logic              req_ready_2;
  logic [ADDR_W-1:0] req_addr_0;
  logic [ADDR_W-1:0] req_addr_1;
  logic [ADDR_W-1:0] req_addr_2;
  logic [DATA_W-1:0] req_data_0;
  logic [DATA_W-1:0] req_data_1;
  logic [DATA_W-1:0] req_data_2;
  logic [TAG_W-1:0]  req_tag_0;
  logic [TAG_W-1:0]  req_tag_1;
  logic [TAG_W-1:0]  req_tag_2;

  logic              reg_write_enable0;
  logic              reg_write_enable1;
  logic [ADDR_W-1:0] data_write0_address;
  logic [ADDR_W-1:0] data_write1_address;
  logic [DATA_W-1:0] data_write0;
  logic [DATA_W-1:0] data_write1;
  logic              r7_written;
  logic [15:0]       conflict_count;

  modport master (
    output req_valid_0, req_valid_1, req_valid_2,
    output req_addr_0, req_addr_1, req_addr_2,
    output req_data_0, req_data_1, req_data_2,
    output req_tag_0, req_tag_1, req_tag_2,
    input  req_ready_0, req_ready_1, req_ready_2,
    input  reg_write_enable0, reg_write_enable1,
    input  data_write0_address, data_write1_address,
    input  data_write0, data_write1,
    input  r7_written, conflict_count
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_valid_2,
    input  req_addr_0, req_addr_1, req_addr_2,
    input  req_data_0, req_data_1, req_data_2,
    input  req_tag_0, req_tag_1, req_tag_2,
    output req_ready_0, req_ready_1, req_ready_2,
    output reg_write_enable0, reg_write_enable1,
    output data_write0_address, data_write1_address,
    output data_write0, data_write1,
    output r7_written, conflict_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries with flush.
// Head is read directly from storage; count drives ready upstream.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  wb_entry_t     din,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Grants the two oldest FIFO heads onto the RF write ports each cycle;
// the older goes on port 0 so port-1 priority preserves program order.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  wb_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    valid;
  logic [2:0]    ready;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic [2:0]    head_v;
  logic [2:0]    g0;
  logic [2:0]    g1;
  wb_entry_t     din  [3];
  wb_entry_t     head [3];
  logic [CW-1:0] cnt  [3];
  wb_entry_t     w0;
  wb_entry_t     w1;
  logic          active;
  logic          en0;
  logic          en1;
  logic [1:0]    rank;
  logic [15:0]   conflict_q;

  assign valid = {bus.req_valid_2, bus.req_valid_1, bus.req_valid_0};
  assign din[0] = '{bus.req_addr_0, bus.req_data_0, bus.req_tag_0};
  assign din[1] = '{bus.req_addr_1, bus.req_data_1, bus.req_tag_1};
  assign din[2] = '{bus.req_addr_2, bus.req_data_2, bus.req_tag_2};

  assign bus.req_ready_0 = ready[0];
  assign bus.req_ready_1 = ready[1];
  assign bus.req_ready_2 = ready[2];

  assign active = !reset && !flush;

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign ready[g]  = active && (cnt[g] < CW'(DEPTH));
    assign push[g]   = valid[g] && ready[g];
    assign head_v[g] = cnt[g] != '0;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (din[g]),
      .head  (head[g]),
      .count (cnt[g])
    );
  end

  // Equal tags are illegal; the lower index wins so ranks stay distinct.
  function automatic logic ahead(
    input logic [TAG_W-1:0] ti,
    input logic [TAG_W-1:0] tj,
    input logic             lower
  );
    return tag_older(ti, tj) || (lower && (ti == tj));
  endfunction

  always_comb begin
    g0   = '0;
    g1   = '0;
    rank = '0;
    for (int i = 0; i < 3; i++) begin
      rank = '0;
      for (int j = 0; j < 3; j++) begin
        if (j != i && head_v[j] &&
            ahead(head[j].tag, head[i].tag, j < i))
          rank = rank + 2'd1;
      end
      g0[i] = head_v[i] && (rank == 2'd0);
      g1[i] = head_v[i] && (rank == 2'd1);
    end
  end

  always_comb begin
    w0 = '0;
    unique case (1'b1)
      g0[0]:   w0 = head[0];
      g0[1]:   w0 = head[1];
      g0[2]:   w0 = head[2];
      default: w0 = '0;
    endcase
  end

  always_comb begin
    w1 = '0;
    unique case (1'b1)
      g1[0]:   w1 = head[0];
      g1[1]:   w1 = head[1];
      g1[2]:   w1 = head[2];
      default: w1 = '0;
    endcase
  end

  assign en0 = active && (g0 != '0);
  assign en1 = active && (g1 != '0);
  assign pop = (g0 & {3{en0}}) | (g1 & {3{en1}});

  assign bus.reg_write_enable0   = en0;
  assign bus.reg_write_enable1   = en1;
  assign bus.data_write0_address = en0 ? w0.addr : '0;
  assign bus.data_write1_address = en1 ? w1.addr : '0;
  assign bus.data_write0         = en0 ? w0.data : '0;
  assign bus.data_write1         = en1 ? w1.data : '0;
  assign bus.r7_written = (en0 && w0.addr == R7) ||
                          (en1 && w1.addr == R7);

  always_ff @(posedge clock) begin
    if (reset)
      conflict_q <= '0;
    else if (active && (&head_v) && conflict_q != 16'hFFFF)
      conflict_q <= conflict_q + 16'd1;
  end

  assign bus.conflict_count = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for the writeback arbiter: directed scenarios, then random
// traffic, all against a queue model ordered by unbounded sequence numbers.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    int          s;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  always #5 clock = ~clock;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  ent_t        q [3][$];
  ent_t        drv_e [3];
  logic        drv_v [3];
  logic [15:0] rf [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cc_m = 0;
  int          next_seq = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int i, input int a, input int d, input int s);
    drv_v[i]   = 1'b1;
    drv_e[i].a = 3'(a);
    drv_e[i].d = 16'(d);
    drv_e[i].s = s;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) drv_v[i] = 1'b0;
  endtask

  task automatic step(input logic rst, input logic fl);
    int          g0;
    int          g1;
    int          nh;
    logic        act;
    logic        e0;
    logic        e1;
    logic [2:0]  ea0;
    logic [2:0]  ea1;
    logic [15:0] ed0;
    logic [15:0] ed1;
    logic        rdy [3];
    logic        we0;
    logic        we1;
    logic [2:0]  wa0;
    logic [2:0]  wa1;
    logic [15:0] wd0;
    logic [15:0] wd1;

    @(negedge clock);
    reset = rst;
    flush = fl;
    bus.req_valid_0 = drv_v[0];
    bus.req_addr_0  = drv_e[0].a;
    bus.req_data_0  = drv_e[0].d;
    bus.req_tag_0   = 4'(drv_e[0].s);
    bus.req_valid_1 = drv_v[1];
    bus.req_addr_1  = drv_e[1].a;
    bus.req_data_1  = drv_e[1].d;
    bus.req_tag_1   = 4'(drv_e[1].s);
    bus.req_valid_2 = drv_v[2];
    bus.req_addr_2  = drv_e[2].a;
    bus.req_data_2  = drv_e[2].d;
    bus.req_tag_2   = 4'(drv_e[2].s);
    #1;

    act = !rst && !fl;
    g0 = -1;
    g1 = -1;
    nh = 0;
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0) begin
        nh++;
        if (g0 < 0 || q[i][0].s < q[g0][0].s) g0 = i;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i != g0 && q[i].size() > 0)
        if (g1 < 0 || q[i][0].s < q[g1][0].s) g1 = i;
    end
    e0  = act && g0 >= 0;
    e1  = act && g1 >= 0;
    ea0 = e0 ? q[g0][0].a : 3'd0;
    ed0 = e0 ? q[g0][0].d : 16'd0;
    ea1 = e1 ? q[g1][0].a : 3'd0;
    ed1 = e1 ? q[g1][0].d : 16'd0;
    for (int i = 0; i < 3; i++) rdy[i] = act && q[i].size() < DEPTH;

    check("en0", bus.reg_write_enable0, e0);
    check("en1", bus.reg_write_enable1, e1);
    check("addr0", bus.data_write0_address, ea0);
    check("addr1", bus.data_write1_address, ea1);
    check("data0", bus.data_write0, ed0);
    check("data1", bus.data_write1, ed1);
    check("r7", bus.r7_written, (e0 && ea0 == 3'd7) || (e1 && ea1 == 3'd7));
    check("ready0", bus.req_ready_0, rdy[0]);
    check("ready1", bus.req_ready_1, rdy[1]);
    check("ready2", bus.req_ready_2, rdy[2]);
    check("conflict", bus.conflict_count, cc_m);

    we0 = bus.reg_write_enable0;
    we1 = bus.reg_write_enable1;
    wa0 = bus.data_write0_address;
    wa1 = bus.data_write1_address;
    wd0 = bus.data_write0;
    wd1 = bus.data_write1;

    @(posedge clock);
    if (we0) rf[wa0] = wd0;
    if (we1) rf[wa1] = wd1;

    if (rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      cc_m = 0;
    end else if (fl) begin
      for (int i = 0; i < 3; i++) q[i].delete();
    end else begin
      if (nh == 3 && cc_m < 65535) cc_m++;
      if (g0 >= 0) void'(q[g0].pop_front());
      if (g1 >= 0) void'(q[g1].pop_front());
      for (int i = 0; i < 3; i++)
        if (drv_v[i] && rdy[i]) q[i].push_back(drv_e[i]);
    end
  endtask

  initial begin
    int   oldest;
    int   rot;
    int   i;
    logic rs;
    logic fl;
    logic rdy_m;

    idle();
    for (int k = 0; k < 3; k++) put(k, 0, 0, 0);
    idle();
    for (int k = 0; k < 8; k++) rf[k] = 16'd0;

    put(0, 1, 'h1234, 0);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0);
    check("first_write_rf1", rf[1], 16'h1234);

    put(1, 3, 'h00AA, 5);
    put(0, 3, 'h00BB, 6);
    step(1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0);
    check("same_addr_rf3", rf[3], 16'h00BB);

    put(2, 4, 'h0002, 2);
    put(0, 5, 'h0003, 3);
    put(1, 6, 'h0004, 4);
    step(1'b0, 1'b0);
    idle();
    repeat (3) step(1'b0, 1'b0);
    check("three_way_rf4", rf[4], 16'h0002);
    check("three_way_rf6", rf[6], 16'h0004);

    put(0, 1, 'h0F15, 15);
    put(1, 1, 'h0F00, 16);
    step(1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0);
    check("wrap_rf1", rf[1], 16'h0F00);

    put(0, 0, 'h0040, 40);
    put(1, 1, 'h0041, 41);
    put(2, 2, 'h0046, 46);
    step(1'b0, 1'b0);
    put(0, 0, 'h0042, 42);
    put(1, 1, 'h0043, 43);
    put(2, 2, 'h0047, 47);
    step(1'b0, 1'b0);
    put(0, 0, 'h0044, 44);
    put(1, 1, 'h0045, 45);
    put(2, 3, 'hDEAD, 99);
    step(1'b0, 1'b0);
    drv_v[0] = 1'b0;
    drv_v[1] = 1'b0;
    step(1'b0, 1'b0);
    idle();
    repeat (3) step(1'b0, 1'b0);
    check("bp_rf2", rf[2], 16'h0047);
    check("bp_rf3", rf[3], 16'h00BB);

    put(0, 2, 'h0060, 60);
    put(1, 4, 'h0061, 61);
    step(1'b0, 1'b0);
    idle();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("flush_rf2", rf[2], 16'h0047);
    put(0, 7, 'h0040, 62);
    step(1'b0, 1'b0);
    idle();
    repeat (2) step(1'b0, 1'b0);
    check("r7_rf7", rf[7], 16'h0040);

    next_seq = 100;
    repeat (1500) begin
      rs = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 39) == 0);
      idle();
      oldest = next_seq;
      for (int k = 0; k < 3; k++)
        if (q[k].size() > 0 && q[k][0].s < oldest) oldest = q[k][0].s;
      rot = $urandom_range(0, 2);
      for (int k = 0; k < 3; k++) begin
        i = (k + rot) % 3;
        rdy_m = !rs && !fl && q[i].size() < DEPTH;
        if ($urandom_range(0, 3) != 0) begin
          if (rdy_m && next_seq - oldest < 7) begin
            put(i, $urandom_range(0, 7), $urandom, next_seq);
            next_seq++;
          end else if (!rdy_m) begin
            put(i, $urandom_range(0, 7), $urandom, next_seq + 3);
          end
        end
      end
      step(rs, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
